mchan_term_evt_unit: RTL and testbench
======================================

MCHAN_TERM_EVT_UNIT -- requirements
Module: mchan_term_evt_unit

Interface
REQ-001 Parameter NB_TRANS, default 16: number of transfer IDs, one per upstream synchronisation unit.
REQ-002 Parameter TRANS_SID_WIDTH, default 4: width of a transfer ID, equal to clog2(NB_TRANS).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 term_sig_i  input  NB_TRANS  one-cycle completion pulse per transfer ID, bit k from synch unit with TRANS_SID=k.
REQ-006 trans_status_i  input  NB_TRANS  per-ID busy level from the synch units.
REQ-007 evt_valid_o  output  1  a completion event is available.
REQ-008 evt_sid_o  output  TRANS_SID_WIDTH  ID of the event at the queue head.
REQ-009 evt_ready_i  input  1  consumer accepts the head event.
REQ-010 clr_req_i  input  1  clear the sticky done bit selected by clr_sid_i.
REQ-011 clr_sid_i  input  TRANS_SID_WIDTH  ID to clear.
REQ-012 done_o  output  NB_TRANS  sticky per-ID completion bitmap.
REQ-013 busy_o  output  1  OR of trans_status_i, registered.
REQ-014 irq_o  output  1  level interrupt, equal to evt_valid_o.
REQ-015 ovf_o  output  1  sticky flag: completion pulse dropped.

Function
REQ-016 Per-ID in-flight bit inflight_q is set when a pulse is accepted and cleared when that ID's event is popped.
REQ-017 Acceptance: a pulse on bit k is accepted iff inflight_q[k]=0; otherwise it is dropped and ovf_o is set.
REQ-018 Candidates each cycle are pend_q OR accepted pulses; the lowest-index candidate is written into the event FIFO that cycle, and the remaining candidates are held in pend_q.
REQ-019 Latency: an accepted pulse with no lower-index candidate appears at evt_sid_o with evt_valid_o=1 in the following cycle.
REQ-020 Event FIFO: depth NB_TRANS, in-order. No duplicates are possible because of inflight_q, so it never overflows; full-with-push is an assertion failure.
REQ-021 Pop occurs when evt_valid_o=1 and evt_ready_i=1. evt_sid_o is stable while evt_valid_o=1 and evt_ready_i=0.
REQ-022 Simultaneous push and pop are both performed, and the occupancy is unchanged.
REQ-023 Pop of ID k together with a new pulse on k: inflight clear wins, and the pulse is dropped with ovf_o set.
REQ-024 Read/write pointers wrap modulo NB_TRANS; the empty/full distinction uses an occupancy counter of width TRANS_SID_WIDTH+1.
REQ-025 done_o[k] is set when ID k is pushed into the FIFO and cleared by clr_req_i with clr_sid_i=k.
REQ-026 Set of done_o[k] and clear of the same k in one cycle: set wins.
REQ-027 ovf_o is cleared only by reset.
REQ-028 busy_o is registered trans_status_i OR-reduction, giving one cycle latency.

Reset
REQ-029 With rst_i=1 at a clock edge, the following are cleared: inflight_q, pend_q, FIFO pointers/count, done_o, ovf_o and busy_o. evt_valid_o and irq_o are 0 from the next cycle.
REQ-030 Reset mid-operation discards all queued and pending events, and pulses arriving in the reset cycle are ignored.

Structure
REQ-031 The default NB_TRANS and the derived TRANS_SID_WIDTH belong in the shared mchan package, next to the existing MCHAN length definitions.
REQ-032 The event queue is a sub-module mchan_evt_fifo (parameters DATA_WIDTH and DEPTH; push/pop/full/empty). The priority selection stays in the top module.

Verification
REQ-033 Single event: pulse term_sig_i[3], evt_ready_i=0 -> next cycle evt_valid_o=1, evt_sid_o=3, done_o[3]=1, irq_o=1; the state holds until ready.
REQ-034 Simultaneous completion: term_sig_i=0x0091 in one cycle, evt_ready_i=1 -> events 0, 4, 7 on three consecutive cycles, then evt_valid_o=0.
REQ-035 Duplicate: pulse ID 5 twice before popping -> one event for 5, and ovf_o=1 after the second pulse.
REQ-036 Full queue: pulse all 16 IDs with evt_ready_i=0 -> count reaches 16 with no assertion. Draining pops IDs 0..15 in order, and a re-pulse of ID 0 after its pop is accepted.
REQ-037 Clear race: clr_req_i with clr_sid_i=2 in the same cycle ID 2 is pushed -> done_o[2]=1. A clear on the next cycle -> done_o[2]=0.
REQ-038 Reset mid-operation: 3 queued events, assert rst_i for one cycle -> evt_valid_o=0, done_o=0, ovf_o=0, and a subsequent pulse on ID 9 yields an event for 9 only.

Source files
------------

// File: rtl/mchan_pkg.sv
// Shared MCHAN definitions: transfer length fields and the transfer-ID space
// used by the synchronisation and termination-event logic.
package mchan_pkg;

    localparam int MCHAN_LEN_WIDTH       = 16;
    localparam int MCHAN_BURST_LENGTH    = 64;
    localparam int MCHAN_OPC_WIDTH       = 1;

    // One transfer ID per upstream synchronisation unit.
    localparam int MCHAN_NB_TRANS        = 16;
    localparam int MCHAN_TRANS_SID_WIDTH = $clog2(MCHAN_NB_TRANS);

endpackage

// File: rtl/mchan_evt_fifo.sv
// In-order event queue with wrapping pointers and an occupancy counter that
// separates the full and empty cases.
module mchan_evt_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mchan_term_evt_unit.sv
// Collects per-ID completion pulses, serialises them lowest-ID-first into an
// event queue, and keeps sticky done/overflow status plus a busy summary.
module mchan_term_evt_unit
    import mchan_pkg::*;
#(
    parameter int NB_TRANS        = MCHAN_NB_TRANS,
    parameter int TRANS_SID_WIDTH = MCHAN_TRANS_SID_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NB_TRANS-1:0]        term_sig_i,
    input  logic [NB_TRANS-1:0]        trans_status_i,
    output logic                       evt_valid_o,
    output logic [TRANS_SID_WIDTH-1:0] evt_sid_o,
    input  logic                       evt_ready_i,
    input  logic                       clr_req_i,
    input  logic [TRANS_SID_WIDTH-1:0] clr_sid_i,
    output logic [NB_TRANS-1:0]        done_o,
    output logic                       busy_o,
    output logic                       irq_o,
    output logic                       ovf_o
);

    logic [NB_TRANS-1:0]        inflight_q, inflight_d;
    logic [NB_TRANS-1:0]        pend_q, pend_d;
    logic [NB_TRANS-1:0]        done_q, done_d;
    logic [NB_TRANS-1:0]        accept, cand, sel_oh, pop_oh, clr_oh;
    logic [TRANS_SID_WIDTH-1:0] sel_sid, head_sid;
    logic                       push, pop, fifo_full, fifo_empty;
    logic                       ovf_q, ovf_d, busy_q;

    always_comb begin
        // An ID already in flight (queued, pending, or being popped now) drops its pulse.
        accept  = term_sig_i & ~inflight_q;
        cand    = pend_q | accept;
        sel_oh  = cand & (~cand + NB_TRANS'(1));
        push    = |cand;
        sel_sid = '0;
        for (int i = NB_TRANS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_sid = TRANS_SID_WIDTH'(i);
            end
        end
        pend_d = cand & ~sel_oh;

        pop    = ~fifo_empty & evt_ready_i;
        pop_oh = '0;
        if (pop) begin
            pop_oh[head_sid] = 1'b1;
        end
        clr_oh = '0;
        if (clr_req_i) begin
            clr_oh[clr_sid_i] = 1'b1;
        end

        inflight_d = (inflight_q & ~pop_oh) | accept;
        done_d     = (done_q & ~clr_oh) | sel_oh;
        ovf_d      = ovf_q | (|(term_sig_i & inflight_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            pend_q     <= '0;
            done_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            busy_q     <= |trans_status_i;
            assert (!(push && fifo_full));
        end
    end

    mchan_evt_fifo #(
        .DATA_WIDTH (TRANS_SID_WIDTH),
        .DEPTH      (NB_TRANS)
    ) i_evt_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (sel_sid),
        .pop_i   (pop),
        .data_o  (head_sid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign evt_valid_o = ~fifo_empty;
    assign evt_sid_o   = head_sid;
    assign irq_o       = ~fifo_empty;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mchan_term_evt_unit.sv
// Directed bench for the termination event unit: event ordering, overflow,
// full queue, sticky done clear race and mid-operation reset.
module tb_mchan_term_evt_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] term_sig_i;
    logic [15:0] trans_status_i;
    logic        evt_valid_o;
    logic [3:0]  evt_sid_o;
    logic        evt_ready_i;
    logic        clr_req_i;
    logic [3:0]  clr_sid_i;
    logic [15:0] done_o;
    logic        busy_o;
    logic        irq_o;
    logic        ovf_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    mchan_term_evt_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .term_sig_i     (term_sig_i),
        .trans_status_i (trans_status_i),
        .evt_valid_o    (evt_valid_o),
        .evt_sid_o      (evt_sid_o),
        .evt_ready_i    (evt_ready_i),
        .clr_req_i      (clr_req_i),
        .clr_sid_i      (clr_sid_i),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .irq_o          (irq_o),
        .ovf_o          (ovf_o)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        term_sig_i     = '0;
        trans_status_i = '0;
        evt_ready_i    = 1'b0;
        clr_req_i      = 1'b0;
        clr_sid_i      = '0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(evt_valid_o), 32'd0);
        check("rst_irq",   32'(irq_o),       32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_ovf",   32'(ovf_o),       32'd0);
        check("rst_busy",  32'(busy_o),      32'd0);

        // busy summary, one cycle behind the status input
        trans_status_i = 16'h0010;
        step();
        check("busy_set", 32'(busy_o), 32'd1);
        trans_status_i = 16'h0000;
        step();
        check("busy_clr", 32'(busy_o), 32'd0);

        // single event held until ready
        term_sig_i = 16'h0008;
        step();
        term_sig_i = '0;
        check("single_valid", 32'(evt_valid_o), 32'd1);
        check("single_sid",   32'(evt_sid_o),   32'd3);
        check("single_done",  32'(done_o),      32'h0008);
        check("single_irq",   32'(irq_o),       32'd1);
        step();
        step();
        check("single_hold_valid", 32'(evt_valid_o), 32'd1);
        check("single_hold_sid",   32'(evt_sid_o),   32'd3);
        evt_ready_i = 1'b1;
        step();
        evt_ready_i = 1'b0;
        check("single_popped", 32'(evt_valid_o), 32'd0);
        check("single_done_kept", 32'(done_o), 32'h0008);
        clr_req_i = 1'b1;
        clr_sid_i = 4'd3;
        step();
        clr_req_i = 1'b0;
        check("single_clear", 32'(done_o), 32'd0);

        // simultaneous completions drain lowest ID first
        do_reset();
        evt_ready_i = 1'b1;
        term_sig_i  = 16'h0091;
        step();
        term_sig_i = '0;
        check("multi_sid0",   32'(evt_sid_o),   32'd0);
        check("multi_v0",     32'(evt_valid_o), 32'd1);
        step();
        check("multi_sid4",   32'(evt_sid_o),   32'd4);
        check("multi_v4",     32'(evt_valid_o), 32'd1);
        step();
        check("multi_sid7",   32'(evt_sid_o),   32'd7);
        check("multi_v7",     32'(evt_valid_o), 32'd1);
        step();
        check("multi_empty",  32'(evt_valid_o), 32'd0);
        check("multi_done",   32'(done_o),      32'h0091);
        evt_ready_i = 1'b0;

        // duplicate pulse before pop
        do_reset();
        term_sig_i = 16'h0020;
        step();
        term_sig_i = '0;
        step();
        check("dup_ovf_before", 32'(ovf_o), 32'd0);
        term_sig_i = 16'h0020;
        step();
        term_sig_i = '0;
        check("dup_ovf", 32'(ovf_o), 32'd1);
        check("dup_sid", 32'(evt_sid_o), 32'd5);
        evt_ready_i = 1'b1;
        step();
        evt_ready_i = 1'b0;
        check("dup_single_event", 32'(evt_valid_o), 32'd0);

        // pop of ID 6 coincident with a new pulse on 6: pulse dropped
        do_reset();
        term_sig_i = 16'h0040;
        step();
        check("race_ovf_before", 32'(ovf_o), 32'd0);
        evt_ready_i = 1'b1;
        step();
        term_sig_i  = '0;
        evt_ready_i = 1'b0;
        check("race_dropped", 32'(evt_valid_o), 32'd0);
        check("race_ovf",     32'(ovf_o),       32'd1);

        // full queue of all 16 IDs, then in-order drain
        do_reset();
        term_sig_i = 16'hFFFF;
        step();
        term_sig_i = '0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("full_done", 32'(done_o), 32'hFFFF);
        check("full_ovf",  32'(ovf_o),  32'd0);
        evt_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), 32'(evt_valid_o), 32'd1);
            check($sformatf("drain_sid_%0d", i),   32'(evt_sid_o),   32'(i));
            step();
        end
        evt_ready_i = 1'b0;
        check("drain_empty", 32'(evt_valid_o), 32'd0);
        term_sig_i = 16'h0001;
        step();
        term_sig_i = '0;
        check("repulse_valid", 32'(evt_valid_o), 32'd1);
        check("repulse_sid",   32'(evt_sid_o),   32'd0);
        check("repulse_ovf",   32'(ovf_o),       32'd0);

        // done set wins over same-cycle clear; next-cycle clear takes effect
        do_reset();
        term_sig_i = 16'h0004;
        clr_req_i  = 1'b1;
        clr_sid_i  = 4'd2;
        step();
        term_sig_i = '0;
        check("clr_race_set", 32'(done_o), 32'h0004);
        step();
        clr_req_i = 1'b0;
        check("clr_after", 32'(done_o), 32'h0000);

        // reset mid-operation discards queued events
        do_reset();
        term_sig_i = 16'h0007;
        step();
        term_sig_i = '0;
        step();
        step();
        term_sig_i = 16'h0001;
        step();
        term_sig_i = '0;
        check("mid_valid_pre", 32'(evt_valid_o), 32'd1);
        check("mid_ovf_pre",   32'(ovf_o),       32'd1);
        check("mid_done_pre",  32'(done_o),      32'h0007);
        rst_i      = 1'b1;
        term_sig_i = 16'h0100;
        step();
        rst_i      = 1'b0;
        term_sig_i = '0;
        check("mid_valid", 32'(evt_valid_o), 32'd0);
        check("mid_done",  32'(done_o),      32'd0);
        check("mid_ovf",   32'(ovf_o),       32'd0);
        step();
        check("mid_ignored", 32'(evt_valid_o), 32'd0);
        term_sig_i = 16'h0200;
        step();
        term_sig_i = '0;
        check("mid_new_valid", 32'(evt_valid_o), 32'd1);
        check("mid_new_sid",   32'(evt_sid_o),   32'd9);
        evt_ready_i = 1'b1;
        step();
        evt_ready_i = 1'b0;
        check("mid_only9",     32'(evt_valid_o), 32'd0);
        check("mid_new_done",  32'(done_o),      32'h0200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
